// File: rtl/proc_pkg.sv
// Shared types and constants for the logic-processor display path.
package proc_pkg;

  typedef enum logic {LIVE, BROWSE} view_state_t;

  localparam int unsigned HIST_DEPTH = 4;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector; rise/fall are combinational against the previous level.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic lvl_q, lvl_d;

  assign lvl_d = d;

  always_ff @(posedge Clk) begin
    if (Reset) lvl_q <= 1'b0;
    else       lvl_q <= lvl_d;
  end

  always_comb begin
    rise = d & ~lvl_q;
    fall = lvl_q & ~d;
  end

endmodule

// File: rtl/result_history.sv
// Circular history of {B,A} snapshots taken at the end of each Execute, browsable with Step.
module result_history
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = HIST_DEPTH,
  parameter int unsigned W     = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Shift_En,
  input  logic [W-1:0]             A,
  input  logic [W-1:0]             B,
  input  logic                     Step,
  input  logic                     Clear,
  output logic [2*W-1:0]           disp_word,
  output logic [$clog2(DEPTH)-1:0] disp_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     browsing
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic cap, stp, sh_rise, stp_fall;
  logic unused_edges;

  edge_detect u_shift_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Shift_En),
    .rise  (sh_rise),
    .fall  (cap)
  );

  edge_detect u_step_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Step),
    .rise  (stp),
    .fall  (stp_fall)
  );

  assign unused_edges = sh_rise ^ stp_fall;

  view_state_t     state_q, state_d;
  logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   off_q, off_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [2*W-1:0]  mem_q [DEPTH];
  logic [2*W-1:0]  mem_d [DEPTH];
  logic [IW-1:0]   idx;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    off_d      = off_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    if (Clear) begin
      // A capture coinciding with Clear is intentionally dropped.
      state_d    = LIVE;
      wr_ptr_d   = '0;
      off_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (cap) begin
      mem_d[wr_ptr_q] = {B, A};
      wr_ptr_d        = wr_ptr_q + IW'(1);
      if (count_q < DepthC) count_d = count_q + CW'(1);
      else                  overflow_d = 1'b1;
      state_d = LIVE;
      off_d   = '0;
    end else if (stp) begin
      unique case (state_q)
        LIVE: begin
          if (count_q != '0) begin
            state_d = BROWSE;
            off_d   = '0;
          end
        end
        BROWSE: begin
          if ({1'b0, off_q} == count_q - CW'(1)) begin
            state_d = LIVE;
            off_d   = '0;
          end else begin
            off_d = off_q + IW'(1);
          end
        end
        default: state_d = LIVE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= LIVE;
      wr_ptr_q   <= '0;
      off_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      off_q      <= off_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  // Newest entry sits just behind the write pointer.
  assign idx = wr_ptr_q - IW'(1) - off_q;

  always_comb begin
    disp_word = (state_q == BROWSE) ? mem_q[idx] : {B, A};
    disp_idx  = off_q;
    count     = count_q;
    overflow  = overflow_q;
    browsing  = (state_q == BROWSE);
  end

endmodule
